// File: rtl/dpp_table_pkg.sv
// Shared event codes, table-view philosopher states and width helpers for the
// dining-philosophers table.
package dpp_table_pkg;

   localparam int unsigned PHILO_EVENT_SIZE = 1;
   localparam int unsigned TABLE_EVENT_SIZE = 1;

   localparam logic [PHILO_EVENT_SIZE-1:0] PHILO_HUNGRY = 1'b0;
   localparam logic [PHILO_EVENT_SIZE-1:0] PHILO_DONE   = 1'b1;
   localparam logic [TABLE_EVENT_SIZE-1:0] TABLE_EAT    = 1'b1;

   typedef enum logic [1:0] {
      StHungry   = 2'd0,
      StThinking = 2'd1,
      StEating   = 2'd2
   } philo_state_e;

   // Width needed to count 0..v-1, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dpp_table_if.sv
// Event bus between the philosopher instances (master) and the table (slave).
interface dpp_table_if #(
   parameter int unsigned N_PHILO = 5
);
   import dpp_table_pkg::*;

   localparam int unsigned PW = PHILO_EVENT_SIZE + 1;
   localparam int unsigned TW = TABLE_EVENT_SIZE + 1;

   logic [N_PHILO*PW-1:0] event_p;
   logic [N_PHILO*TW-1:0] event_s;

   modport master (output event_p, input event_s);
   modport slave  (input event_p, output event_s);

endinterface

// File: rtl/dpp_table_seat.sv
// One philosopher seat as seen by the table: valid edge detect, event decode, state
// tracking and, with DPP_STARVE_MON_EN defined, a saturating hunger counter.
module dpp_table_seat
   import dpp_table_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        evt_valid,
   input  logic [PHILO_EVENT_SIZE-1:0] evt_code,
   input  logic                        grant,
   output logic                        hungry,
   output logic                        eating,
   output logic                        done,
   output logic                        err,
   output logic                        starve
);

   if (STARVE_LIMIT < 1) begin : g_limit_check
      $error("STARVE_LIMIT must be at least 1");
   end

   logic                        valid_q;
   logic                        evt_q;
   logic [PHILO_EVENT_SIZE-1:0] code_q;
   philo_state_e                state_q, state_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         evt_q   <= 1'b0;
         code_q  <= '0;
         state_q <= StThinking;
      end else begin
         valid_q <= evt_valid;
         evt_q   <= evt_valid & ~valid_q;
         if (evt_valid && !valid_q) code_q <= evt_code;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err     = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StThinking: begin
            if (evt_q) begin
               if (code_q == PHILO_HUNGRY) state_d = StHungry;
               else                        err     = 1'b1;
            end
         end
         StHungry: begin
            // Any event while waiting for forks is illegal; a grant still proceeds.
            err = evt_q;
            if (grant) state_d = StEating;
         end
         StEating: begin
            if (evt_q) begin
               if (code_q == PHILO_DONE) begin
                  state_d = StThinking;
                  done    = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
         end
         default: state_d = StThinking;
      endcase
   end

   assign hungry = (state_q == StHungry);
   assign eating = (state_q == StEating);

`ifdef DPP_STARVE_MON_EN
   localparam int unsigned CW = clog2_min1(STARVE_LIMIT + 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = '0;
      if (state_q == StHungry && state_d == StHungry) begin
         count_d = (count_q >= CW'(STARVE_LIMIT)) ? count_q : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign starve = hungry && (count_q >= CW'(STARVE_LIMIT));
`else
   assign starve = 1'b0;
`endif

endmodule

// File: rtl/dpp_table.sv
// Dining-philosophers table: owns the forks and grants EAT round-robin to hungry
// philosophers. Hunger monitoring is built only when DPP_STARVE_MON_EN is defined.
module dpp_table
   import dpp_table_pkg::*;
#(
   parameter int unsigned N_PHILO      = 5,
   parameter int unsigned STARVE_LIMIT = 255
) (
   input  logic               clk,
   input  logic               reset,
   dpp_table_if.slave         bus,
   output logic [N_PHILO-1:0] eating,
   output logic [N_PHILO-1:0] fork_busy,
   output logic               proto_err,
   output logic [N_PHILO-1:0] starve
);

   if (N_PHILO < 2 || N_PHILO > 16) begin : g_size_check
      $error("N_PHILO must be in 2..16");
   end

   localparam int unsigned PW = PHILO_EVENT_SIZE + 1;
   localparam int unsigned TW = TABLE_EVENT_SIZE + 1;
   localparam int unsigned RW = clog2_min1(N_PHILO);

   logic [N_PHILO-1:0]    hungry, done, err, grant;
   logic [N_PHILO-1:0]    fork_q, fork_d, eat_pulse_q;
   logic [RW-1:0]         rr_q, rr_d;
   logic                  proto_err_q;
   logic [N_PHILO*TW-1:0] event_s_v;

   for (genvar i = 0; i < N_PHILO; i++) begin : g_seat
      dpp_table_seat #(
         .STARVE_LIMIT (STARVE_LIMIT)
      ) u_seat (
         .clk       (clk),
         .reset     (reset),
         .evt_valid (bus.event_p[i*PW + PHILO_EVENT_SIZE]),
         .evt_code  (bus.event_p[i*PW +: PHILO_EVENT_SIZE]),
         .grant     (grant[i]),
         .hungry    (hungry[i]),
         .eating    (eating[i]),
         .done      (done[i]),
         .err       (err[i]),
         .starve    (starve[i])
      );
   end

   // Round-robin scan from rr_q for the first hungry seat with both forks free.
   always_comb begin
      int unsigned idx, nxt;
      logic        found;
      grant = '0;
      rr_d  = rr_q;
      found = 1'b0;
      idx   = 0;
      nxt   = 0;
      for (int unsigned off = 0; off < N_PHILO; off++) begin
         idx = (rr_q + off) % N_PHILO;
         nxt = (idx + 1) % N_PHILO;
         if (!found && hungry[idx] && !fork_q[idx] && !fork_q[nxt]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            rr_d       = RW'(nxt);
         end
      end
   end

   // Releases only touch forks owned by the leaver, so they never collide with a grant.
   always_comb begin
      fork_d = fork_q;
      for (int i = 0; i < N_PHILO; i++) begin
         if (done[i]) begin
            fork_d[i]                 = 1'b0;
            fork_d[(i + 1) % N_PHILO] = 1'b0;
         end
      end
      for (int i = 0; i < N_PHILO; i++) begin
         if (grant[i]) begin
            fork_d[i]                 = 1'b1;
            fork_d[(i + 1) % N_PHILO] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fork_q      <= '0;
         rr_q        <= '0;
         eat_pulse_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         fork_q      <= fork_d;
         rr_q        <= rr_d;
         eat_pulse_q <= grant;
         proto_err_q <= proto_err_q | (|err);
      end
   end

   always_comb begin
      event_s_v = '0;
      for (int i = 0; i < N_PHILO; i++) begin
         if (eat_pulse_q[i]) event_s_v[i*TW +: TW] = {1'b1, TABLE_EAT};
      end
   end

   assign bus.event_s = event_s_v;
   assign fork_busy   = fork_q;
   assign proto_err   = proto_err_q;

   logic [N_PHILO-1:0] eat_rot;
   assign eat_rot = {eating[N_PHILO-2:0], eating[N_PHILO-1]};

   fork_owner_consistent: assert property (@(posedge clk) fork_q == (eating | eat_rot));

endmodule

// File: tb/tb_dpp_table.sv
// Directed plus randomized bench for dpp_table against a fork-ownership reference model.
module tb_dpp_table;
   import dpp_table_pkg::*;

   localparam int unsigned N     = 5;
   localparam int unsigned LIMIT = 8;
   localparam int THINK = 0;
   localparam int HUNG  = 1;
   localparam int EATS  = 2;

   logic         clk;
   logic         reset;
   logic [N-1:0] eating, fork_busy, starve;
   logic         proto_err;

   dpp_table_if #(.N_PHILO(N)) bus ();

   dpp_table #(
      .N_PHILO      (N),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .eating    (eating),
      .fork_busy (fork_busy),
      .proto_err (proto_err),
      .starve    (starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: seat states, fork owners (-1 = on the table), pending events.
   int       st    [N];
   int       owner [N];
   int       age   [N];
   bit       prev_v[N];
   bit       pend  [N];
   bit       pend_c[N];
   int       rr;
   bit       perr;
   bit [N-1:0] exp_es;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit rst_n, input bit [N-1:0] in_v, input bit [N-1:0] in_c);
      int g;
      int new_st[N];
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            st[i] = THINK; owner[i] = -1; age[i] = 0;
            prev_v[i] = 0; pend[i] = 0; pend_c[i] = 0;
         end
         rr = 0; perr = 0; exp_es = '0;
         return;
      end
      g = -1;
      for (int off = 0; off < N; off++) begin
         int p;
         p = (rr + off) % N;
         if (g < 0 && st[p] == HUNG && owner[p] < 0 && owner[(p + 1) % N] < 0) g = p;
      end
      for (int i = 0; i < N; i++) new_st[i] = st[i];
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            if (pend_c[i] == PHILO_HUNGRY && st[i] == THINK) new_st[i] = HUNG;
            else if (pend_c[i] == PHILO_DONE && st[i] == EATS) begin
               new_st[i] = THINK; owner[i] = -1; owner[(i + 1) % N] = -1;
            end else perr = 1;
         end
      end
      exp_es = '0;
      if (g >= 0) begin
         new_st[g] = EATS; owner[g] = g; owner[(g + 1) % N] = g;
         rr = (g + 1) % N;
         exp_es[g] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         age[i] = (st[i] == HUNG && new_st[i] == HUNG) ? age[i] + 1 : 0;
         st[i]  = new_st[i];
         pend[i] = in_v[i] & ~prev_v[i];
         if (pend[i]) pend_c[i] = in_c[i];
         prev_v[i] = in_v[i];
      end
   endtask

   task automatic check_all();
      logic [2*N-1:0] exp_s;
      logic [N-1:0]   exp_eat, exp_fork, exp_starve;
      for (int i = 0; i < N; i++) begin
         exp_s[2*i +: 2] = exp_es[i] ? {1'b1, TABLE_EAT} : 2'b00;
         exp_eat[i]      = (st[i] == EATS);
         exp_fork[i]     = (owner[i] >= 0);
`ifdef DPP_STARVE_MON_EN
         exp_starve[i]   = (st[i] == HUNG) && (age[i] >= LIMIT);
`else
         exp_starve[i]   = 1'b0;
`endif
      end
      chk("event_s", 32'(bus.event_s), 32'(exp_s));
      chk("eating", 32'(eating), 32'(exp_eat));
      chk("fork_busy", 32'(fork_busy), 32'(exp_fork));
      chk("proto_err", 32'(proto_err), 32'(perr));
      chk("starve", 32'(starve), 32'(exp_starve));
      chk("no_adjacent_eaters", 32'(eating & {eating[N-2:0], eating[N-1]}), 32'(0));
   endtask

   task automatic step();
      bit [N-1:0] in_v, in_c;
      bit         r;
      for (int i = 0; i < N; i++) begin
         in_v[i] = bus.event_p[2*i + 1];
         in_c[i] = bus.event_p[2*i];
      end
      r = reset;
      @(posedge clk);
      model_edge(r, in_v, in_c);
      #1;
      check_all();
   endtask

   task automatic set_ev(input int i, input bit v, input logic code);
      bus.event_p[2*i + 1] = v;
      if (v) bus.event_p[2*i] = code;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.event_p = '0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      bus.event_p = '0;
      #1;

      // Reset held with random events on the bus.
      for (int c = 0; c < 3; c++) begin
         bus.event_p = 10'($urandom);
         step();
         chk("rst_event_s", 32'(bus.event_s), 32'(0));
      end
      bus.event_p = '0;
      reset = 1'b1;
      step();

      // Single meal for philo 2.
      set_ev(2, 1, PHILO_HUNGRY); step();
      set_ev(2, 0, PHILO_HUNGRY); step();
      chk("meal_no_early_pulse", 32'(bus.event_s), 32'(0));
      step();
      chk("meal_eat_pulse", 32'(bus.event_s), 32'(10'b00_00_11_00_00));
      chk("meal_fork_busy", 32'(fork_busy), 32'(5'b01100));
      step();
      chk("meal_pulse_one_cycle", 32'(bus.event_s), 32'(0));
      set_ev(2, 1, PHILO_DONE); step();
      set_ev(2, 0, PHILO_DONE); step();
      chk("meal_forks_freed", 32'(fork_busy), 32'(0));

      // Contention between 0 and 1.
      do_reset();
      set_ev(0, 1, PHILO_HUNGRY); set_ev(1, 1, PHILO_HUNGRY); step();
      set_ev(0, 0, PHILO_HUNGRY); set_ev(1, 0, PHILO_HUNGRY); step(); step();
      chk("contend_eat0", 32'(bus.event_s), 32'(10'b00_00_00_00_11));
      step();
      set_ev(0, 1, PHILO_DONE); step();
      set_ev(0, 0, PHILO_DONE); step(); step();
      chk("contend_eat1", 32'(bus.event_s), 32'(10'b00_00_00_11_00));

      // Everyone hungry at once.
      do_reset();
      for (int i = 0; i < N; i++) set_ev(i, 1, PHILO_HUNGRY);
      step();
      bus.event_p = '0;
      step(); step();
      chk("all_eat0", 32'(bus.event_s), 32'(10'b00_00_00_00_11));
      step();
      chk("all_eat2", 32'(bus.event_s), 32'(10'b00_00_11_00_00));
      for (int c = 0; c < 5; c++) step();
      chk("all_eating", 32'(eating), 32'(5'b00101));

      // Reset in the middle of a meal.
      reset = 1'b0; step();
      chk("midmeal_eating", 32'(eating), 32'(0));
      reset = 1'b1; step();

      // DONE from a thinking philosopher.
      set_ev(3, 1, PHILO_DONE); step();
      set_ev(3, 0, PHILO_DONE); step();
      chk("err_sticky", 32'(proto_err), 32'(1));
      chk("err_state_kept", 32'(eating), 32'(0));
      step(); step();

      // Held-high valid yields one event only.
      do_reset();
      set_ev(3, 1, PHILO_HUNGRY);
      for (int c = 0; c < 10; c++) step();
      set_ev(3, 0, PHILO_HUNGRY); step();
      chk("held_eating", 32'(eating), 32'(5'b01000));
      chk("held_no_err", 32'(proto_err), 32'(0));

      // Philo 1 starved by both neighbours.
      do_reset();
      set_ev(0, 1, PHILO_HUNGRY); set_ev(2, 1, PHILO_HUNGRY); step();
      bus.event_p = '0; step(); step(); step();
      set_ev(1, 1, PHILO_HUNGRY); step();
      set_ev(1, 0, PHILO_HUNGRY);
      for (int c = 0; c < LIMIT + 4; c++) step();
      set_ev(0, 1, PHILO_DONE); set_ev(2, 1, PHILO_DONE); step();
      bus.event_p = '0;
      for (int c = 0; c < 4; c++) step();
      chk("starve_cleared", 32'(starve), 32'(0));
      chk("starve_granted", 32'(eating[1]), 32'(1));

      // Randomized traffic, mostly protocol-legal, with one reset pulse.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) begin
               if (bus.event_p[2*i + 1]) begin
                  bus.event_p[2*i + 1] = 1'b0;
               end else begin
                  bit dn;
                  dn = ($urandom_range(9) == 0) ? (st[i] != EATS) : (st[i] == EATS);
                  set_ev(i, 1, dn ? PHILO_DONE : PHILO_HUNGRY);
               end
            end
         end
         reset = (c != 200);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
